// File: rtl/fat32_bpb_parser_if.sv
// SD-card sector read bus between the BPB parser and the sector-read controller.
// The parser is the master: it issues the request and consumes the byte stream.
interface fat32_bpb_parser_if;
   logic        sd_rd_req;
   logic [31:0] sd_rd_addr;
   logic        sd_rd_data_en;
   logic [7:0]  sd_rd_data;

   modport master (
      output sd_rd_req,
      output sd_rd_addr,
      input  sd_rd_data_en,
      input  sd_rd_data
   );

   modport slave (
      input  sd_rd_req,
      input  sd_rd_addr,
      output sd_rd_data_en,
      output sd_rd_data
   );
endinterface

// File: rtl/fat32_bpb_parser.sv
// FAT32 boot-sector parser: requests the BPB sector, captures geometry fields
// straight from the byte stream and sanity-checks them before publishing.
module fat32_bpb_parser #(
   parameter logic [31:0] BPB_SECTOR   = 32'd0,
   parameter int          SECTOR_BYTES = 512
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst_n,
   input  logic                      parse_start,
   fat32_bpb_parser_if.master        sd,
   output logic [15:0]               ReservedSectors,
   output logic [31:0]               theLengthOfFAT,
   output logic [8:0]                NumberOfFAT,
   output logic [7:0]                SectorsPerCluster,
   output logic [31:0]               RootCluster,
   output logic                      bpb_busy,
   output logic                      bpb_valid,
   output logic                      bpb_error
);

   localparam logic [15:0] SECTOR_BPS = 16'(SECTOR_BYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_RECV,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [8:0]  byte_cnt;
   logic [15:0] bytes_per_sec;
   logic [7:0]  sig_lo;
   logic [7:0]  sig_hi;
   logic        start_ok;
   logic        take;
   logic        last_byte;
   logic        bpb_ok;

   assign start_ok  = parse_start &&
                      (state == S_IDLE || state == S_DONE || state == S_ERROR);
   assign take      = (state == S_RECV) && sd.sd_rd_data_en;
   assign last_byte = take && (byte_cnt == 9'd511);

   // Sector is accepted only with a boot signature and sane geometry.
   assign bpb_ok = (sig_lo == 8'h55) && (sig_hi == 8'hAA) &&
                   (bytes_per_sec == SECTOR_BPS) &&
                   (NumberOfFAT != 9'd0) &&
                   (SectorsPerCluster != 8'd0) &&
                   ((SectorsPerCluster & (SectorsPerCluster - 8'd1)) == 8'd0) &&
                   (theLengthOfFAT != 32'd0);

   // State register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= S_IDLE;
      else            state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_ok) state_nxt = S_REQ;
         S_REQ:   state_nxt = S_RECV;
         S_RECV:  if (last_byte) state_nxt = S_CHECK;
         S_CHECK: state_nxt = bpb_ok ? S_DONE : S_ERROR;
         S_DONE:  if (start_ok) state_nxt = S_REQ;
         S_ERROR: if (start_ok) state_nxt = S_REQ;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Status and request outputs decoded from the state.
   always_comb begin
      sd.sd_rd_req  = (state == S_REQ);
      sd.sd_rd_addr = BPB_SECTOR;
      bpb_busy      = (state == S_REQ) || (state == S_RECV) ||
                      (state == S_CHECK);
      bpb_valid     = (state == S_DONE);
      bpb_error     = (state == S_ERROR);
   end

   // Byte counter: cleared on request, advanced per accepted byte.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)          byte_cnt <= 9'd0;
      else if (state == S_REQ) byte_cnt <= 9'd0;
      else if (take)           byte_cnt <= byte_cnt + 9'd1;
   end

   // Little-endian field capture directly from the stream.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ReservedSectors   <= '0;
         theLengthOfFAT    <= '0;
         NumberOfFAT       <= '0;
         SectorsPerCluster <= '0;
         RootCluster       <= '0;
         bytes_per_sec     <= '0;
         sig_lo            <= '0;
         sig_hi            <= '0;
      end else if (take) begin
         case (byte_cnt)
            9'd11:  bytes_per_sec[7:0]    <= sd.sd_rd_data;
            9'd12:  bytes_per_sec[15:8]   <= sd.sd_rd_data;
            9'd13:  SectorsPerCluster     <= sd.sd_rd_data;
            9'd14:  ReservedSectors[7:0]  <= sd.sd_rd_data;
            9'd15:  ReservedSectors[15:8] <= sd.sd_rd_data;
            9'd16:  NumberOfFAT           <= {1'b0, sd.sd_rd_data};
            9'd36:  theLengthOfFAT[7:0]   <= sd.sd_rd_data;
            9'd37:  theLengthOfFAT[15:8]  <= sd.sd_rd_data;
            9'd38:  theLengthOfFAT[23:16] <= sd.sd_rd_data;
            9'd39:  theLengthOfFAT[31:24] <= sd.sd_rd_data;
            9'd44:  RootCluster[7:0]      <= sd.sd_rd_data;
            9'd45:  RootCluster[15:8]     <= sd.sd_rd_data;
            9'd46:  RootCluster[23:16]    <= sd.sd_rd_data;
            9'd47:  RootCluster[31:24]    <= sd.sd_rd_data;
            9'd510: sig_lo                <= sd.sd_rd_data;
            9'd511: sig_hi                <= sd.sd_rd_data;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fat32_bpb_parser.sv
// Directed + randomized bench for the FAT32 BPB parser.
// Expected fields and verdict come from a byte-array model of the boot sector.
module tb_fat32_bpb_parser;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        parse_start = 1'b0;
   logic [15:0] ReservedSectors;
   logic [31:0] theLengthOfFAT;
   logic [8:0]  NumberOfFAT;
   logic [7:0]  SectorsPerCluster;
   logic [31:0] RootCluster;
   logic        bpb_busy;
   logic        bpb_valid;
   logic        bpb_error;

   fat32_bpb_parser_if sd_if ();

   fat32_bpb_parser #(
      .BPB_SECTOR   (32'd0),
      .SECTOR_BYTES (512)
   ) dut (
      .sys_clk           (sys_clk),
      .sys_rst_n         (sys_rst_n),
      .parse_start       (parse_start),
      .sd                (sd_if.master),
      .ReservedSectors   (ReservedSectors),
      .theLengthOfFAT    (theLengthOfFAT),
      .NumberOfFAT       (NumberOfFAT),
      .SectorsPerCluster (SectorsPerCluster),
      .RootCluster       (RootCluster),
      .bpb_busy          (bpb_busy),
      .bpb_valid         (bpb_valid),
      .bpb_error         (bpb_error)
   );

   always #5 sys_clk = ~sys_clk;

   int n_assert = 0;
   int n_fail = 0;
   int req_seen = 0;

   logic [7:0] img [512];
   int exp_res, exp_fat, exp_nf, exp_spc, exp_root, exp_bps;
   bit exp_ok;

   // Count read requests seen on the bus.
   always @(posedge sys_clk) begin
      if (sd_if.sd_rd_req === 1'b1) req_seen <= req_seen + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Standard image: random filler plus the known geometry.
   task automatic build_std();
      for (int i = 0; i < 512; i++) img[i] = 8'($urandom);
      img[11] = 8'h00; img[12] = 8'h02;
      img[13] = 8'd8;
      img[14] = 8'h20; img[15] = 8'h00;
      img[16] = 8'd2;
      img[36] = 8'hC1; img[37] = 8'h03; img[38] = 8'h00; img[39] = 8'h00;
      img[44] = 8'h02; img[45] = 8'h00; img[46] = 8'h00; img[47] = 8'h00;
      img[510] = 8'h55; img[511] = 8'hAA;
   endtask

   // Reference: decode the sector array with plain arithmetic.
   task automatic model();
      exp_bps  = int'(img[11]) + 256 * int'(img[12]);
      exp_spc  = int'(img[13]);
      exp_res  = int'(img[14]) + 256 * int'(img[15]);
      exp_nf   = int'(img[16]);
      exp_fat  = int'(img[36]) + (int'(img[37]) << 8) +
                 (int'(img[38]) << 16) + (int'(img[39]) << 24);
      exp_root = int'(img[44]) + (int'(img[45]) << 8) +
                 (int'(img[46]) << 16) + (int'(img[47]) << 24);
      exp_ok   = (img[510] == 8'h55) && (img[511] == 8'hAA) &&
                 (exp_bps == 512) && (exp_nf != 0) &&
                 ($countones(exp_spc) == 1) && (exp_fat != 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " res0"}, 32'(ReservedSectors), 0);
      chk({tag, " fat0"}, theLengthOfFAT, 0);
      chk({tag, " nf0"}, 32'(NumberOfFAT), 0);
      chk({tag, " spc0"}, 32'(SectorsPerCluster), 0);
      chk({tag, " root0"}, RootCluster, 0);
      chk({tag, " busy0"}, 32'(bpb_busy), 0);
      chk({tag, " valid0"}, 32'(bpb_valid), 0);
      chk({tag, " err0"}, 32'(bpb_error), 0);
      chk({tag, " req0"}, 32'(sd_if.sd_rd_req), 0);
   endtask

   // One parse: optional random gaps, mid-stream start, or reset at a byte.
   task automatic run(input string tag, input int drop_pct,
                      input int start_at, input int rst_at);
      int base;
      int i;
      model();
      base = req_seen;
      @(posedge sys_clk); #1 parse_start = 1'b1;
      @(posedge sys_clk); #1 parse_start = 1'b0;
      chk({tag, " req"}, 32'(sd_if.sd_rd_req), 1);
      chk({tag, " addr"}, sd_if.sd_rd_addr, 0);
      chk({tag, " busy"}, 32'(bpb_busy), 1);
      chk({tag, " startclr"}, {bpb_valid, bpb_error}, 0);
      @(posedge sys_clk); #1;
      i = 0;
      while (i < 512) begin
         if (i == rst_at) begin
            sd_if.sd_rd_data_en = 1'b0;
            sys_rst_n = 1'b0;
            #1;
            chk_zero({tag, " inrst"});
            @(posedge sys_clk); #1;
            sys_rst_n = 1'b1;
            #1;
            chk_zero({tag, " postrst"});
            return;
         end
         if (drop_pct > 0 && $urandom_range(99) < drop_pct) begin
            sd_if.sd_rd_data_en = 1'b0;
            sd_if.sd_rd_data = 8'($urandom);
         end else begin
            sd_if.sd_rd_data_en = 1'b1;
            sd_if.sd_rd_data = img[i];
            parse_start = (i == start_at);
            i++;
         end
         @(posedge sys_clk); #1;
         parse_start = 1'b0;
      end
      sd_if.sd_rd_data_en = 1'b0;
      chk({tag, " chkstate"}, {bpb_busy, bpb_valid, bpb_error}, 3'b100);
      @(posedge sys_clk); #1;
      chk({tag, " valid"}, 32'(bpb_valid), exp_ok ? 1 : 0);
      chk({tag, " error"}, 32'(bpb_error), exp_ok ? 0 : 1);
      chk({tag, " busy"}, 32'(bpb_busy), 0);
      chk({tag, " nreq"}, req_seen - base, 1);
      chk({tag, " res"}, 32'(ReservedSectors), exp_res);
      chk({tag, " fat"}, theLengthOfFAT, exp_fat);
      chk({tag, " nf"}, 32'(NumberOfFAT), exp_nf);
      chk({tag, " spc"}, 32'(SectorsPerCluster), exp_spc);
      chk({tag, " root"}, RootCluster, exp_root);
      if (exp_ok)
         chk({tag, " rootdir"},
             32'(ReservedSectors) + 32'(NumberOfFAT) * theLengthOfFAT,
             exp_res + exp_nf * exp_fat);
      for (int k = 0; k < 8; k++) begin
         sd_if.sd_rd_data_en = 1'b1;
         sd_if.sd_rd_data = 8'hFF;
         @(posedge sys_clk); #1;
      end
      sd_if.sd_rd_data_en = 1'b0;
      chk({tag, " hold res"}, 32'(ReservedSectors), exp_res);
      chk({tag, " hold root"}, RootCluster, exp_root);
      chk({tag, " hold valid"}, 32'(bpb_valid), exp_ok ? 1 : 0);
   endtask

   initial begin
      sd_if.sd_rd_data_en = 1'b0;
      sd_if.sd_rd_data = 8'h00;
      repeat (2) @(posedge sys_clk);
      #1;
      chk_zero("reset");
      sys_rst_n = 1'b1;

      build_std();
      run("std", 0, -1, -1);
      chk("std 1954", 32'(ReservedSectors) + 32'(NumberOfFAT) * theLengthOfFAT,
          32'd1954);
      chk("std values", {ReservedSectors, NumberOfFAT[7:0], SectorsPerCluster},
          32'h0020_0208);

      run("gap", 50, -1, -1);

      img[511] = 8'h00;
      run("badsig", 0, -1, -1);
      build_std();
      run("recover", 0, -1, -1);

      build_std();
      img[11] = 8'h00; img[12] = 8'h10;
      run("bps4096", 0, -1, -1);
      build_std();
      img[13] = 8'd6;
      run("spc6", 0, -1, -1);
      build_std();
      img[16] = 8'd0;
      run("nf0", 0, -1, -1);

      build_std();
      run("midstart", 0, 100, -1);

      build_std();
      run("rst", 0, -1, 300);
      run("afterrst", 0, -1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
